// File: rtl/elevator_scan_fsm.sv
// SCAN-scheduled elevator controller: serves a registered request bitmap, sweeping one direction before reversing.
// Optional feature: define ELEVATOR_DOOR_REOPEN_EN to restart the door timer on a same-floor request while open.
module elevator_scan_fsm #(
    parameter int FLOORS        = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic               i_fsm_clock,
    input  logic               i_fsm_reset,
    input  logic               i_req_valid,
    input  logic [FLOOR_W-1:0] i_req_floor,
    input  logic               i_fsm_error_flag,
    input  logic               i_fsm_error_clear,
    output logic               o_fsm_move_up,
    output logic               o_fsm_move_down,
    output logic               o_fsm_open_door,
    output logic               o_fsm_alarm,
    output logic [FLOOR_W-1:0] o_fsm_floor,
    output logic [FLOORS-1:0]  o_fsm_pending,
    output logic               o_fsm_req_err
);

    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, ERROR} state_t;

    localparam logic [7:0]         TRAVEL_LAST = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0]         DOOR_LAST   = 8'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS - 1);

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_up_q, dir_up_d;
    logic [FLOORS-1:0]  pending_q, pending_d;
    logic [7:0]         travel_q, travel_d;
    logic [7:0]         door_q, door_d;
    logic               req_err_q;
    logic               move_up_q, move_down_q, open_door_q, alarm_q;

    logic [FLOORS-1:0]  req_mask, eff_pend, cur_mask;
    logic               req_bad, arrive, moving_up, reopen;

    function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i == int'(f)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(f)) r = r | p[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i < int'(f)) r = r | p[i];
        end
        return r;
    endfunction

    always_comb begin
        // Out-of-range floors produce an empty mask, so only valid requests reach the bitmap.
        req_mask  = i_req_valid ? onehot(i_req_floor) : '0;
        req_bad   = i_req_valid && (int'(i_req_floor) >= FLOORS);
        eff_pend  = pending_q | req_mask;
        cur_mask  = onehot(floor_q);
        pending_d = (state_q == DOOR_OPEN) ? (eff_pend & ~cur_mask) : eff_pend;
`ifdef ELEVATOR_DOOR_REOPEN_EN
        reopen    = |(req_mask & cur_mask);
`else
        reopen    = 1'b0;
`endif
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        travel_d  = travel_q;
        door_d    = door_q;
        arrive    = 1'b0;
        moving_up = (state_q == MOVE_UP);

        case (state_q)
            IDLE: begin
                travel_d = '0;
                door_d   = '0;
                if (|(eff_pend & cur_mask)) begin
                    state_d = DOOR_OPEN;
                end else if (any_above(eff_pend, floor_q) &&
                             (dir_up_q || !any_below(eff_pend, floor_q))) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (any_below(eff_pend, floor_q)) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (travel_q == TRAVEL_LAST) begin
                    travel_d = '0;
                    arrive   = 1'b1;
                    if (moving_up && floor_q != TOP_FLOOR) begin
                        floor_d = floor_q + FLOOR_W'(1);
                    end else if (!moving_up && floor_q != '0) begin
                        floor_d = floor_q - FLOOR_W'(1);
                    end
                end else begin
                    travel_d = travel_q + 8'd1;
                end
            end
            DOOR_OPEN: begin
                if (reopen) begin
                    door_d = '0;
                end else if (door_q == DOOR_LAST) begin
                    state_d = IDLE;
                    door_d  = '0;
                end else begin
                    door_d = door_q + 8'd1;
                end
            end
            ERROR: begin
                travel_d = '0;
                door_d   = '0;
                if (i_fsm_error_clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Arrival decision is made against the floor just reached, not the one left.
        if (arrive) begin
            if (|(eff_pend & onehot(floor_d))) begin
                state_d = DOOR_OPEN;
                door_d  = '0;
            end else if (moving_up ? any_above(eff_pend, floor_d) : any_below(eff_pend, floor_d)) begin
                state_d = state_q;
            end else if (moving_up ? any_below(eff_pend, floor_d) : any_above(eff_pend, floor_d)) begin
                state_d  = moving_up ? MOVE_DOWN : MOVE_UP;
                dir_up_d = !moving_up;
            end else begin
                state_d = IDLE;
            end
        end

        if (i_fsm_error_flag) begin
            state_d  = ERROR;
            floor_d  = floor_q;
            travel_d = '0;
            door_d   = '0;
        end
    end

    always_ff @(posedge i_fsm_clock or negedge i_fsm_reset) begin
        if (!i_fsm_reset) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            dir_up_q    <= 1'b1;
            pending_q   <= '0;
            travel_q    <= '0;
            door_q      <= '0;
            req_err_q   <= 1'b0;
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
            open_door_q <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            pending_q   <= pending_d;
            travel_q    <= travel_d;
            door_q      <= door_d;
            req_err_q   <= req_bad;
            move_up_q   <= (state_d == MOVE_UP);
            move_down_q <= (state_d == MOVE_DOWN);
            open_door_q <= (state_d == DOOR_OPEN);
            alarm_q     <= (state_d == ERROR);
        end
    end

    assign o_fsm_move_up   = move_up_q;
    assign o_fsm_move_down = move_down_q;
    assign o_fsm_open_door = open_door_q;
    assign o_fsm_alarm     = alarm_q;
    assign o_fsm_floor     = floor_q;
    assign o_fsm_pending   = pending_q;
    assign o_fsm_req_err   = req_err_q;

endmodule

// File: tb/tb_elevator_scan_fsm.sv
// Scoreboard bench for elevator_scan_fsm: a countdown-based elevator model predicts each cycle's outputs,
// a monitor pops and compares them; directed scenarios plus randomized traffic and faults.
module tb_elevator_scan_fsm;

    localparam int FLOORS = 8;
    localparam int FW     = 4;
    localparam int TRAVEL = 4;
    localparam int DOOR   = 6;
`ifdef ELEVATOR_DOOR_REOPEN_EN
    localparam int DOOR_REOPEN_TOTAL = 10;
`else
    localparam int DOOR_REOPEN_TOTAL = 6;
`endif

    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3, M_ERR = 4;

    typedef struct packed {
        logic              up;
        logic              down;
        logic              door;
        logic              alarm;
        logic              req_err;
        logic [FW-1:0]     floor;
        logic [FLOORS-1:0] pend;
    } obs_t;

    logic              clk, rst_n, req_valid, eflag, eclr;
    logic [FW-1:0]     req_floor;
    logic              move_up, move_down, open_door, alarm, req_err;
    logic [FW-1:0]     floor_o;
    logic [FLOORS-1:0] pending;

    int checks = 0;
    int errors = 0;
    int n_up = 0, n_down = 0, n_door = 0;
    obs_t exp_q[$];

    // behavioural model state
    int m_mode, m_floor, m_left;
    bit m_up, m_rerr;
    bit m_pend[FLOORS];
    bit m_eff[FLOORS];

    elevator_scan_fsm #(.FLOORS(FLOORS), .FLOOR_W(FW), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
        .i_fsm_clock      (clk),
        .i_fsm_reset      (rst_n),
        .i_req_valid      (req_valid),
        .i_req_floor      (req_floor),
        .i_fsm_error_flag (eflag),
        .i_fsm_error_clear(eclr),
        .o_fsm_move_up    (move_up),
        .o_fsm_move_down  (move_down),
        .o_fsm_open_door  (open_door),
        .o_fsm_alarm      (alarm),
        .o_fsm_floor      (floor_o),
        .o_fsm_pending    (pending),
        .o_fsm_req_err    (req_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t a;
        a.up = move_up; a.down = move_down; a.door = open_door; a.alarm = alarm;
        a.req_err = req_err; a.floor = floor_o; a.pend = pending;
        return a;
    endfunction

    function automatic obs_t model_obs();
        obs_t e;
        e.up = (m_mode == M_UP); e.down = (m_mode == M_DOWN);
        e.door = (m_mode == M_DOOR); e.alarm = (m_mode == M_ERR);
        e.req_err = m_rerr; e.floor = m_floor[FW-1:0];
        for (int i = 0; i < FLOORS; i++) e.pend[i] = m_pend[i];
        return e;
    endfunction

    function automatic bit pend_above(int fl);
        for (int i = fl + 1; i < FLOORS; i++) if (m_eff[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_below(int fl);
        for (int i = 0; i < fl; i++) if (m_eff[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit all_clear();
        for (int i = 0; i < FLOORS; i++) if (m_pend[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_floor = 0; m_left = 0; m_up = 1'b1; m_rerr = 1'b0;
        for (int i = 0; i < FLOORS; i++) m_pend[i] = 1'b0;
    endtask

    // Advance the model across one clock edge given the inputs sampled on it.
    task automatic model_step(input bit v, input int f, input bit ef, input bit ec);
        bit hit, fwd, back, reopen;
        hit = v && (f < FLOORS);
        m_rerr = v && (f >= FLOORS);
        m_eff = m_pend;
        if (hit) m_eff[f] = 1'b1;
        m_pend = m_eff;
        if (m_mode == M_DOOR) m_pend[m_floor] = 1'b0;
        if (ef) begin
            m_mode = M_ERR;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (m_eff[m_floor]) begin
                        m_mode = M_DOOR; m_left = DOOR;
                    end else if (pend_above(m_floor) && (m_up || !pend_below(m_floor))) begin
                        m_mode = M_UP; m_up = 1'b1; m_left = TRAVEL;
                    end else if (pend_below(m_floor)) begin
                        m_mode = M_DOWN; m_up = 1'b0; m_left = TRAVEL;
                    end
                end
                M_UP, M_DOWN: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_floor += (m_mode == M_UP) ? 1 : -1;
                        fwd  = (m_mode == M_UP) ? pend_above(m_floor) : pend_below(m_floor);
                        back = (m_mode == M_UP) ? pend_below(m_floor) : pend_above(m_floor);
                        if (m_eff[m_floor]) begin
                            m_mode = M_DOOR; m_left = DOOR;
                        end else if (fwd) begin
                            m_left = TRAVEL;
                        end else if (back) begin
                            m_mode = (m_mode == M_UP) ? M_DOWN : M_UP;
                            m_up = (m_mode == M_UP);
                            m_left = TRAVEL;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                M_DOOR: begin
                    reopen = 1'b0;
`ifdef ELEVATOR_DOOR_REOPEN_EN
                    reopen = hit && (f == m_floor);
`endif
                    if (reopen) begin
                        m_left = DOOR;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_mode = M_IDLE;
                    end
                end
                default: if (ec) m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic cycle(input bit v, input int f, input bit ef, input bit ec);
        @(negedge clk);
        req_valid = v; req_floor = f[FW-1:0]; eflag = ef; eclr = ec;
        model_step(v, f, ef, ec);
        exp_q.push_back(model_obs());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while (!(m_mode == M_IDLE && all_clear()) && k < budget) begin
            cycle(1'b0, 0, 1'b0, 1'b0);
            k++;
        end
        settle();
        checks++;
        if (!(m_mode == M_IDLE && all_clear())) begin
            errors++;
            $display("FAIL idle_timeout actual=busy after %0d cycles required=idle", budget);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_obs(input string name, input obs_t req);
        obs_t a;
        a = sample();
        checks++;
        if (a !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, a, req);
        end
    endtask

    // Monitor: compares DUT outputs with the predicted entry after every edge that has one queued.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t actual up=%b dn=%b door=%b alarm=%b rerr=%b floor=%0d pend=%b required up=%b dn=%b door=%b alarm=%b rerr=%b floor=%0d pend=%b",
                             $time, a.up, a.down, a.door, a.alarm, a.req_err, a.floor, a.pend,
                             e.up, e.down, e.door, e.alarm, e.req_err, e.floor, e.pend);
                end
                if (a.up) n_up++;
                if (a.down) n_down++;
                if (a.door) n_door++;
            end
        end
    end

    initial begin
        int u0, d0, o0, hold, k;
        bit v, ef, ec;
        int f;
        rst_n = 1'b0; req_valid = 1'b0; req_floor = '0; eflag = 1'b0; eclr = 1'b0;
        model_reset();
        #8;
        check_obs("reset_state", '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Floor 0 -> 3: 12 travel cycles, 6 door cycles.
        u0 = n_up; o0 = n_door;
        cycle(1'b1, 3, 1'b0, 1'b0);
        run_until_idle(100);
        check_int("up_cycles_0_to_3", n_up - u0, 12);
        check_int("door_cycles_at_3", n_door - o0, 6);
        check_int("floor_after_3", int'(floor_o), 3);

        // From 3 going up with {5,1}: serve 5, then reverse down to 1.
        u0 = n_up; d0 = n_down; o0 = n_door;
        cycle(1'b1, 5, 1'b0, 1'b0);
        cycle(1'b1, 1, 1'b0, 1'b0);
        run_until_idle(200);
        check_int("up_cycles_3_to_5", n_up - u0, 8);
        check_int("down_cycles_5_to_1", n_down - d0, 16);
        check_int("door_cycles_two_stops", n_door - o0, 12);

        // Fault while moving up; clear ignored while flag stays high.
        cycle(1'b1, 6, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        settle();
        check_int("alarm_after_fault", int'(alarm), 1);
        check_int("move_up_after_fault", int'(move_up), 0);
        repeat (3) cycle(1'b0, 0, 1'b1, 1'b1);
        cycle(1'b1, 4, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1);
        run_until_idle(200);

        // Out-of-range request: one-cycle error pulse, bitmap untouched.
        cycle(1'b1, 9, 1'b0, 1'b0);
        settle();
        check_int("req_err_pulse", int'(req_err), 1);
        check_int("pending_after_bad_req", int'(pending), 0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        settle();
        check_int("req_err_drop", int'(req_err), 0);

        // Same-floor request on door cycle 4.
        o0 = n_door;
        f = m_floor;
        cycle(1'b1, f, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, f, 1'b0, 1'b0);
        run_until_idle(100);
        check_int("door_reopen_total", n_door - o0, DOOR_REOPEN_TOTAL);

        // Asynchronous reset mid-move at floor 2.
        cycle(1'b1, 0, 1'b0, 1'b0);
        k = 0;
        while (!(m_floor == 2 && m_mode == M_DOWN) && k < 100) begin
            cycle(1'b0, 0, 1'b0, 1'b0);
            k++;
        end
        check_int("reached_floor2_moving", (m_floor == 2 && m_mode == M_DOWN) ? 1 : 0, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_obs("async_reset_mid_move", '0);
        model_reset();
        #1 rst_n = 1'b1;
        cycle(1'b1, 2, 1'b0, 1'b0);
        run_until_idle(100);

        // Randomized traffic, bad requests and faults.
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 2) == 0);
            f = int'($urandom_range(0, 15));
            if (hold > 0) begin
                ef = 1'b1; hold--;
            end else if ($urandom_range(0, 59) == 0) begin
                ef = 1'b1; hold = int'($urandom_range(0, 3));
            end else begin
                ef = 1'b0;
            end
            ec = ($urandom_range(0, 3) == 0);
            cycle(v, f, ef, ec);
        end
        cycle(1'b0, 0, 1'b0, 1'b1);
        run_until_idle(600);
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
